// File: rtl/mmio_fifo_pkg.sv
// mmio_fifo_pkg: shared definitions for the MMIO FIFO bank.
//   STAT register bit positions, response payload struct and the
//   address decoder that maps an MMIO word address onto {kind, channel}.
// Config macro: MMIO_FIFO_PEEK_EN enables decoding of the PEEK range.
package mmio_fifo_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned TID_W      = 9;
    localparam int unsigned RSP_DATA_W = 64;
    localparam int unsigned CH_W       = 3;

    localparam int unsigned STAT_CNT_LSB = 0;
    localparam int unsigned STAT_CNT_W   = 16;
    localparam int unsigned STAT_EMPTY   = 16;
    localparam int unsigned STAT_FULL    = 17;
    localparam int unsigned STAT_OVF     = 18;
    localparam int unsigned STAT_UNF     = 19;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_DATA = 2'd1,
        KIND_STAT = 2'd2,
        KIND_PEEK = 2'd3
    } t_kind;

    typedef struct packed {
        t_kind           kind;
        logic [CH_W-1:0] ch;
    } t_decode;

    typedef struct packed {
        logic                  valid;
        logic                  hit;
        logic [TID_W-1:0]      tid;
        logic [RSP_DATA_W-1:0] data;
    } t_mmio_rsp;

    // Odd offsets and addresses below base wrap to a miss.
    function automatic t_decode decode_addr(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] base,
                                            input logic [ADDR_W-1:0] num_ch);
        logic [ADDR_W-1:0] off;
        logic [ADDR_W-1:0] idx;
        t_decode           d;
        off    = addr - base;
        idx    = {1'b0, off[ADDR_W-1:1]};
        d.kind = KIND_NONE;
        d.ch   = '0;
        if (!off[0]) begin
            if (idx < num_ch) begin
                d.kind = KIND_DATA;
                d.ch   = CH_W'(idx);
            end else if (idx < (num_ch << 1)) begin
                d.kind = KIND_STAT;
                d.ch   = CH_W'(idx - num_ch);
            end
`ifdef MMIO_FIFO_PEEK_EN
            else if (idx < ((num_ch << 1) + num_ch)) begin
                d.kind = KIND_PEEK;
                d.ch   = CH_W'(idx - (num_ch << 1));
            end
`endif
        end
        return d;
    endfunction

endpackage

// File: rtl/mmio_fifo_bank_chan.sv
// mmio_fifo_chan: one circular-buffer FIFO channel with sticky flags.
//   push_req/pop_req : requests; a push when full sets ovf, a pop when empty sets unf
//   wdata            : entry to store on push
//   clr_ovf/clr_unf  : W1C clears of the sticky flags
//   head_c           : current head entry (combinational)
//   cnt_q            : occupancy, 0..DEPTH
//   full_c/empty_c   : occupancy compares
//   ovf_q/unf_q      : sticky overflow/underflow
module mmio_fifo_chan #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_req,
    input  logic                     pop_req,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     clr_ovf,
    input  logic                     clr_unf,
    output logic [DATA_W-1:0]        head_c,
    output logic [$clog2(DEPTH):0]   cnt_q,
    output logic                     full_c,
    output logic                     empty_c,
    output logic                     ovf_q,
    output logic                     unf_q
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_d, unf_d;
    logic              push_en_c, pop_en_c;

    assign full_c    = (cnt_q == CNT_W'(DEPTH));
    assign empty_c   = (cnt_q == '0);
    assign push_en_c = push_req & ~full_c;
    assign pop_en_c  = pop_req & ~empty_c;
    assign head_c    = mem_q[rd_ptr_q];

    // Pointer/count/flag update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_en_c) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
        end else if (pop_en_c) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = cnt_q - 1'b1;
        end
        ovf_d = (ovf_q & ~clr_ovf) | (push_req & full_c);
        unf_d = (unf_q & ~clr_unf) | (pop_req & empty_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_en_c) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_fifo_bank.sv
// mmio_fifo_bank: NUM_CH MMIO-mapped FIFOs behind the CCI-P MMIO decode.
//   clk, rst_n                     : clock, async active-low reset
//   mmio_wr/mmio_rd                : write/read request strobes
//   mmio_addr/mmio_tid/mmio_wdata  : request header and write data
//   rsp_valid/rsp_tid/rsp_data     : registered read response, 1-cycle latency
//   rsp_hit                        : response address fell inside the bank
//   irq_ovf                        : registered OR of all overflow flags
// Config macro: MMIO_FIFO_PEEK_EN adds non-popping PEEK[c] reads.
module mmio_fifo_bank
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DATA_W    = 64,
    parameter logic [15:0] BASE_ADDR = 16'h0020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mmio_wr,
    input  logic        mmio_rd,
    input  logic [15:0] mmio_addr,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wdata,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        rsp_hit,
    output logic        irq_ovf
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    t_decode           dec_c;
    logic              wr_op_c;
    logic [NUM_CH-1:0] push_c, pop_c, clr_ovf_c, clr_unf_c;
    logic [NUM_CH-1:0] full_c, empty_c, ovf_q, unf_q;
    logic [DATA_W-1:0] head_c [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    t_mmio_rsp         rsp_q, rsp_d;
    logic              irq_q, irq_d;

    assign dec_c   = decode_addr(mmio_addr, BASE_ADDR, ADDR_W'(NUM_CH));
    // A write colliding with a read is dropped entirely.
    assign wr_op_c = mmio_wr & ~mmio_rd;

    // Steer the single MMIO op to its channel.
    always_comb begin
        push_c    = '0;
        pop_c     = '0;
        clr_ovf_c = '0;
        clr_unf_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (dec_c.ch == CH_W'(c)) begin
                push_c[c]    = wr_op_c & (dec_c.kind == KIND_DATA);
                pop_c[c]     = mmio_rd & (dec_c.kind == KIND_DATA);
                clr_ovf_c[c] = wr_op_c & (dec_c.kind == KIND_STAT) & mmio_wdata[STAT_OVF];
                clr_unf_c[c] = wr_op_c & (dec_c.kind == KIND_STAT) & mmio_wdata[STAT_UNF];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mmio_fifo_chan #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .push_req (push_c[g]),
            .pop_req  (pop_c[g]),
            .wdata    (mmio_wdata[DATA_W-1:0]),
            .clr_ovf  (clr_ovf_c[g]),
            .clr_unf  (clr_unf_c[g]),
            .head_c   (head_c[g]),
            .cnt_q    (cnt_q[g]),
            .full_c   (full_c[g]),
            .empty_c  (empty_c[g]),
            .ovf_q    (ovf_q[g]),
            .unf_q    (unf_q[g])
        );
    end

    // Response mux; idle cycles register an all-zero response.
    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = mmio_rd;
        if (mmio_rd) begin
            rsp_d.tid = mmio_tid;
            rsp_d.hit = (dec_c.kind != KIND_NONE);
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (dec_c.ch == CH_W'(c)) begin
                    case (dec_c.kind)
                        KIND_DATA: begin
                            if (!empty_c[c]) begin
                                rsp_d.data = RSP_DATA_W'(head_c[c]);
                            end
                        end
                        KIND_STAT: begin
                            rsp_d.data[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(cnt_q[c]);
                            rsp_d.data[STAT_EMPTY]                 = empty_c[c];
                            rsp_d.data[STAT_FULL]                  = full_c[c];
                            rsp_d.data[STAT_OVF]                   = ovf_q[c];
                            rsp_d.data[STAT_UNF]                   = unf_q[c];
                        end
`ifdef MMIO_FIFO_PEEK_EN
                        KIND_PEEK: begin
                            if (!empty_c[c]) begin
                                rsp_d.data = RSP_DATA_W'(head_c[c]);
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
        irq_d = |ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
            irq_q <= 1'b0;
        end else begin
            rsp_q <= rsp_d;
            irq_q <= irq_d;
        end
    end

    assign rsp_valid = rsp_q.valid;
    assign rsp_hit   = rsp_q.hit;
    assign rsp_tid   = rsp_q.tid;
    assign rsp_data  = rsp_q.data;
    assign irq_ovf   = irq_q;

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// tb_mmio_fifo_bank: directed scoreboard bench for mmio_fifo_bank (default parameters).
// Build with MMIO_FIFO_PEEK_EN to exercise the PEEK range.
module tb_mmio_fifo_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mmio_wr, mmio_rd;
    logic [15:0] mmio_addr;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wdata;
    logic        rsp_valid, rsp_hit, irq_ovf;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    always #5 clk = ~clk;

    mmio_fifo_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mmio_wr    (mmio_wr),
        .mmio_rd    (mmio_rd),
        .mmio_addr  (mmio_addr),
        .mmio_tid   (mmio_tid),
        .mmio_wdata (mmio_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_tid    (rsp_tid),
        .rsp_data   (rsp_data),
        .rsp_hit    (rsp_hit),
        .irq_ovf    (irq_ovf)
    );

    typedef struct {
        logic        hit;
        logic [8:0]  tid;
        logic [63:0] data;
    } t_exp;

    int          errors = 0;
    int          checks = 0;
    t_exp        sb [$];
    logic [63:0] mq [4][$];
    bit          m_ovf [4];
    bit          m_unf [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: 0 miss, 1 DATA, 2 STAT, 3 PEEK.
    function automatic int bdec(input logic [15:0] addr, output int ch);
        int off, idx;
        off = int'(addr) - 32'h20;
        ch  = 0;
        if (off < 0 || (off % 2) != 0) return 0;
        idx = off / 2;
        if (idx < 4) begin ch = idx; return 1; end
        if (idx < 8) begin ch = idx - 4; return 2; end
`ifdef MMIO_FIFO_PEEK_EN
        if (idx < 12) begin ch = idx - 8; return 3; end
`endif
        return 0;
    endfunction

    function automatic logic [63:0] stat_of(input int ch);
        int n;
        n = mq[ch].size();
        return {44'b0, 1'(m_unf[ch]), 1'(m_ovf[ch]), 1'(n == 16), 1'(n == 0), 16'(n)};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            mq[c].delete();
            m_ovf[c] = 1'b0;
            m_unf[c] = 1'b0;
        end
    endtask

    task automatic mmio_write(input logic [15:0] addr, input logic [63:0] data);
        int k, ch;
        k = bdec(addr, ch);
        if (k == 1) begin
            if (mq[ch].size() < 16) mq[ch].push_back(data);
            else m_ovf[ch] = 1'b1;
        end else if (k == 2) begin
            if (data[18]) m_ovf[ch] = 1'b0;
            if (data[19]) m_unf[ch] = 1'b0;
        end
        @(negedge clk);
        mmio_wr = 1'b1; mmio_addr = addr; mmio_wdata = data;
        @(negedge clk);
        mmio_wr = 1'b0;
    endtask

    // Read (optionally colliding with a write that must be ignored).
    task automatic mmio_read(input logic [15:0] addr, input string tag,
                             input bit with_wr = 1'b0, input logic [63:0] wdata = '0);
        t_exp        e, got;
        int          k, ch, n;
        logic [8:0]  tid;
        tid    = 9'($urandom_range(0, 511));
        k      = bdec(addr, ch);
        e.hit  = (k != 0);
        e.tid  = tid;
        e.data = '0;
        if (k == 1) begin
            if (mq[ch].size() > 0) e.data = mq[ch].pop_front();
            else m_unf[ch] = 1'b1;
        end else if (k == 2) begin
            e.data = stat_of(ch);
        end else if (k == 3) begin
            if (mq[ch].size() > 0) e.data = mq[ch][0];
        end
        sb.push_back(e);
        @(negedge clk);
        mmio_rd = 1'b1; mmio_wr = with_wr; mmio_addr = addr; mmio_tid = tid; mmio_wdata = wdata;
        @(negedge clk);
        mmio_rd = 1'b0; mmio_wr = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        got = sb.pop_front();
        chk({tag, ".hit"},  64'(rsp_hit),  64'(got.hit));
        chk({tag, ".tid"},  64'(rsp_tid),  64'(got.tid));
        chk({tag, ".data"}, rsp_data,      got.data);
    endtask

    initial begin
        rst_n = 1'b0; mmio_wr = 1'b0; mmio_rd = 1'b0;
        mmio_addr = '0; mmio_tid = '0; mmio_wdata = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst.valid", 64'(rsp_valid), 64'd0);
        chk("rst.hit",   64'(rsp_hit),   64'd0);
        chk("rst.tid",   64'(rsp_tid),   64'd0);
        chk("rst.data",  rsp_data,       64'd0);
        chk("rst.irq",   64'(irq_ovf),   64'd0);

        // Basic FIFO order on channel 0.
        mmio_write(16'h0020, 64'hA1);
        mmio_write(16'h0020, 64'hA2);
        mmio_write(16'h0020, 64'hA3);
        mmio_read(16'h0020, "ch0.rd0");
        @(negedge clk);
        chk("ch0.one_cycle_valid", 64'(rsp_valid), 64'd0);
        mmio_read(16'h0020, "ch0.rd1");
        mmio_read(16'h0020, "ch0.rd2");
        mmio_read(16'h0028, "ch0.stat");
        chk("ch0.stat_const", rsp_data, 64'h10000);

        // Overflow on channel 1 and irq timing.
        for (int i = 0; i < 17; i++) mmio_write(16'h0022, 64'h100 + 64'(i));
        chk("ovf.irq_not_yet", 64'(irq_ovf), 64'd0);
        @(negedge clk);
        chk("ovf.irq_rise", 64'(irq_ovf), 64'd1);
        mmio_read(16'h002A, "ch1.stat_full");
        chk("ch1.stat_const", rsp_data, 64'h60010);
        mmio_read(16'h0022, "ch1.first");
        mmio_write(16'h002A, 64'h1 << 18);
        chk("ovf.irq_hold", 64'(irq_ovf), 64'd1);
        @(negedge clk);
        chk("ovf.irq_drop", 64'(irq_ovf), 64'd0);
        mmio_read(16'h002A, "ch1.stat_clr");

        // Underflow on empty channel 2.
        mmio_read(16'h0024, "ch2.empty_rd");
        mmio_read(16'h002C, "ch2.stat_unf");
        chk("ch2.stat_const", rsp_data, 64'h90000);

        // Channel 3 pointer wrap.
        for (int i = 0; i < 40; i++) begin
            mmio_write(16'h0026, 64'hC000 + 64'(i));
            if (i >= 4) mmio_read(16'h0026, "ch3.wrap");
        end
        for (int i = 0; i < 4; i++) mmio_read(16'h0026, "ch3.drain");
        mmio_read(16'h002E, "ch3.stat");
        mmio_read(16'h0028, "ch0.stat_after");
        mmio_read(16'h002A, "ch1.stat_after");
        mmio_read(16'h002C, "ch2.stat_after");

        // Read+write collision: read served, W1C write ignored.
        mmio_read(16'h002C, "coll.rd", 1'b1, 64'h1 << 19);
        mmio_read(16'h002C, "coll.unf_kept");

        // Out-of-bank and misaligned addresses.
        mmio_read(16'h001E, "oob.below");
        mmio_read(16'h0021, "oob.odd");
        mmio_read(16'h002F, "oob.odd_stat");
        mmio_read(16'h0040, "oob.above");

        // PEEK range (miss when the feature is not built).
        mmio_write(16'h0020, 64'h55);
        mmio_read(16'h0030, "peek.rd0");
        mmio_read(16'h0030, "peek.rd1");
        mmio_read(16'h0028, "peek.stat");
        mmio_read(16'h0020, "peek.pop");

        // Reset during an in-flight read drops the response.
        mmio_write(16'h0020, 64'h77);
        mmio_write(16'h0020, 64'h78);
        @(negedge clk);
        mmio_rd = 1'b1; mmio_addr = 16'h0020; mmio_tid = 9'h1AB;
        #2 rst_n = 1'b0;
        @(negedge clk);
        mmio_rd = 1'b0;
        chk("rstmid.valid0", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("rstmid.valid1", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        model_clear();
        chk("rstmid.irq", 64'(irq_ovf), 64'd0);
        mmio_read(16'h0028, "rstmid.stat0");
        chk("rstmid.stat0_const", rsp_data, 64'h10000);
        mmio_read(16'h002A, "rstmid.stat1");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
